// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// Each access is grant -> ACCESS -> DONE (ack), so one transaction completes every three cycles.
module mem_arbiter #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 16,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  sel_q, sel_d;
    logic                  last_q, last_d;
    logic                  a_we_q, a_we_d;
    logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
    logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
    logic                  win;
    logic [1:0]            ack_vec;

    // Contested grant: fixed mode favours port 0, round-robin favours the port not served last.
    always_comb begin
        win = req1;
        if (req0 && req1) begin
            win = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        a_we_d    = a_we_q;
        a_addr_d  = a_addr_q;
        a_wdata_d = a_wdata_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d   = ACCESS;
                    sel_d     = win;
                    a_we_d    = win ? we1    : we0;
                    a_addr_d  = win ? addr1  : addr0;
                    a_wdata_d = win ? wdata1 : wdata0;
                end
            end
            ACCESS: state_d = DONE;
            DONE: begin
                last_d  = sel_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            a_we_q    <= 1'b0;
            a_addr_q  <= '0;
            a_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            a_we_q    <= a_we_d;
            a_addr_q  <= a_addr_d;
            a_wdata_q <= a_wdata_d;
        end
    end

    // Gating with rst keeps an aborted transaction from writing or acking at the reset edge.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
        assign ack_vec[gi] = (state_q == DONE) && (sel_q == gi[0]) && !rst;
    end

    assign ack0     = ack_vec[0];
    assign ack1     = ack_vec[1];
    assign busy     = (state_q != IDLE);
    assign mem_we   = (state_q == ACCESS) && a_we_q && !rst;
    assign mem_addr = a_addr_q;
    assign mem_data = a_wdata_q;
    assign rdata    = mem_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a fixed-priority instance share stimulus,
// each with its own memory, checked every cycle against a transaction-level model.
module tb_mem_arbiter;
    localparam int AW = 6;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic [1:0]    ack0_w, ack1_w, busy_w, mem_we_w;
    logic [AW-1:0] mem_addr_w [2];
    logic [DW-1:0] mem_data_w [2];
    logic [DW-1:0] rdata_w    [2];
    logic [DW-1:0] mem_out_w  [2];

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(0)) dut_rr (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_w[0]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_w[0]),
        .rdata(rdata_w[0]), .busy(busy_w[0]), .mem_we(mem_we_w[0]),
        .mem_addr(mem_addr_w[0]), .mem_data(mem_data_w[0]), .mem_out(mem_out_w[0])
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_w[1]),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_w[1]),
        .rdata(rdata_w[1]), .busy(busy_w[1]), .mem_we(mem_we_w[1]),
        .mem_addr(mem_addr_w[1]), .mem_data(mem_data_w[1]), .mem_out(mem_out_w[1])
    );

    // Memories attached to the two instances, preloaded with A000+addr.
    logic [DW-1:0] tmem [2][64];
    bit tinit = 1'b0;
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!tinit) begin
                for (int i = 0; i < 64; i++) tmem[k][i] <= 16'hA000 + 16'(i);
            end else if (mem_we_w[k]) begin
                tmem[k][mem_addr_w[k]] <= mem_data_w[k];
            end
            mem_out_w[k] <= tmem[k][mem_addr_w[k]];
        end
        tinit <= 1'b1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input int inst,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d actual=%h required=%h", name, inst, cyc, act, exp);
        end
    endfunction

    // Transaction model: one pending access per arbiter, aged 0 (memory cycle) then 1 (ack cycle).
    bit            m_pv   [2];
    bit            m_port [2];
    bit            m_we   [2];
    bit            m_last [2];
    int            m_age  [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_wd   [2];
    logic [DW-1:0] mmem   [2][64];
    bit            minit = 1'b0;

    always @(posedge clk) begin
        bit p;
        if (!minit) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 64; i++) mmem[k][i] = 16'hA000 + 16'(i);
            minit = 1'b1;
        end
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pv[k]   = 1'b0;
                m_last[k] = 1'b1;
            end else if (m_pv[k]) begin
                if (m_age[k] == 0) begin
                    if (m_we[k]) mmem[k][m_addr[k]] = m_wd[k];
                    m_age[k] = 1;
                end else begin
                    m_last[k] = m_port[k];
                    m_pv[k]   = 1'b0;
                end
            end else if (req0 || req1) begin
                if (req0 && req1) p = (k == 1) ? 1'b0 : !m_last[k];
                else              p = req1;
                m_pv[k]   = 1'b1;
                m_age[k]  = 0;
                m_port[k] = p;
                m_we[k]   = p ? we1 : we0;
                m_addr[k] = p ? addr1 : addr0;
                m_wd[k]   = p ? wdata1 : wdata0;
            end
        end
    end

    typedef struct {
        int            port;
        int            cyc;
        logic [DW-1:0] data;
    } ack_t;
    ack_t rr_log[$];
    ack_t fp_log[$];
    int   we_cnt [2] = '{0, 0};

    always @(negedge clk) begin
        ack_t a;
        bit e_ack0, e_ack1, e_we;
        if (cyc >= 1) begin
            for (int k = 0; k < 2; k++) begin
                e_ack0 = m_pv[k] && m_age[k] == 1 && !m_port[k] && !rst;
                e_ack1 = m_pv[k] && m_age[k] == 1 &&  m_port[k] && !rst;
                e_we   = m_pv[k] && m_age[k] == 0 &&  m_we[k]   && !rst;
                chk("busy",   k, 32'(busy_w[k]),   32'(m_pv[k]));
                chk("ack0",   k, 32'(ack0_w[k]),   32'(e_ack0));
                chk("ack1",   k, 32'(ack1_w[k]),   32'(e_ack1));
                chk("mem_we", k, 32'(mem_we_w[k]), 32'(e_we));
                if (m_pv[k] && m_age[k] == 0) begin
                    chk("mem_addr", k, 32'(mem_addr_w[k]), 32'(m_addr[k]));
                    if (m_we[k]) chk("mem_data", k, 32'(mem_data_w[k]), 32'(m_wd[k]));
                end
                if ((e_ack0 || e_ack1) && !m_we[k])
                    chk("rdata", k, 32'(rdata_w[k]), 32'(mmem[k][m_addr[k]]));
                if (mem_we_w[k]) we_cnt[k]++;
                if (ack0_w[k] || ack1_w[k]) begin
                    a.port = ack1_w[k] ? 1 : 0;
                    a.cyc  = cyc;
                    a.data = rdata_w[k];
                    if (k == 0) rr_log.push_back(a);
                    else        fp_log.push_back(a);
                    $display("txn inst=%0d port=%0d cyc=%0d rdata=%h", k, a.port, cyc, a.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic access(input int port, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data);
        if (port == 0) begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data;
        end else begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data;
        end
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) tick();
    endtask

    int   g, c0, wc;
    int   port1_seen;
    int   exp_rr_port [5] = '{0, 1, 0, 1, 1};
    int   exp_fp_port [5] = '{0, 0, 0, 0, 1};
    logic [DW-1:0] exp_rr_data [5] = '{16'hA001, 16'hA002, 16'hA001, 16'hA002, 16'hA002};
    logic [DW-1:0] exp_fp_data [5] = '{16'hA001, 16'hA001, 16'hA001, 16'hA001, 16'hA002};

    initial begin
        rst = 1'b1; req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy",     k, 32'(busy_w[k]),     0);
            chk("rst_ack0",     k, 32'(ack0_w[k]),     0);
            chk("rst_ack1",     k, 32'(ack1_w[k]),     0);
            chk("rst_mem_we",   k, 32'(mem_we_w[k]),   0);
            chk("rst_mem_addr", k, 32'(mem_addr_w[k]), 0);
            chk("rst_mem_data", k, 32'(mem_data_w[k]), 0);
        end
        rst = 1'b0;
        tick();

        // Port 0 write of BEEF to address 5, then read back.
        rr_log.delete(); fp_log.delete();
        wc = we_cnt[0];
        req0 = 1'b1; we0 = 1'b1; addr0 = 6'd5; wdata0 = 16'hBEEF;
        tick();
        g = cyc;
        req0 = 1'b0;
        repeat (3) tick();
        chk("wr_we_pulses", 0, we_cnt[0] - wc, 1);
        chk("wr_ack_count", 0, rr_log.size(), 1);
        chk("wr_ack_cycle", 0, rr_log[0].cyc, g + 1);
        chk("wr_ack_port",  0, rr_log[0].port, 0);
        access(0, 1'b0, 6'd5, '0);
        chk("rd_beef", 0, 32'(rr_log[1].data), 32'h0000BEEF);
        chk("rd_beef", 1, 32'(fp_log[1].data), 32'h0000BEEF);
        port1_seen = 0;
        foreach (rr_log[i]) if (rr_log[i].port == 1) port1_seen++;
        chk("rd_no_ack1", 0, port1_seen, 0);

        // Reset lands in the ACCESS cycle of a port 0 write to address 3.
        rr_log.delete(); fp_log.delete();
        req0 = 1'b1; we0 = 1'b1; addr0 = 6'd3; wdata0 = 16'h5555;
        tick();
        rst = 1'b1;
        req0 = 1'b0;
        #1;
        chk("abort_mem_we", 0, 32'(mem_we_w[0]), 0);
        chk("abort_mem_we", 1, 32'(mem_we_w[1]), 0);
        tick();
        chk("abort_busy", 0, 32'(busy_w[0]), 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("abort_no_ack", 0, rr_log.size(), 0);
        chk("abort_no_ack", 1, fp_log.size(), 0);

        // Both ports contend for 12 cycles, then port 1 alone.
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 6'd2;
        tick();
        c0 = cyc;
        repeat (11) tick();
        req0 = 1'b0;
        tick();
        req1 = 1'b0;
        repeat (3) tick();
        chk("rr_count", 0, rr_log.size(), 5);
        chk("fp_count", 1, fp_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("rr_port", 0, rr_log[i].port, exp_rr_port[i]);
            chk("rr_cyc",  0, rr_log[i].cyc,  c0 + 1 + 3 * i);
            chk("rr_data", 0, 32'(rr_log[i].data), 32'(exp_rr_data[i]));
            chk("fp_port", 1, fp_log[i].port, exp_fp_port[i]);
            chk("fp_cyc",  1, fp_log[i].cyc,  c0 + 1 + 3 * i);
            chk("fp_data", 1, 32'(fp_log[i].data), 32'(exp_fp_data[i]));
        end

        // Fields change right after the grant of a port 1 write.
        rr_log.delete(); fp_log.delete();
        req1 = 1'b1; we1 = 1'b1; addr1 = 6'd9; wdata1 = 16'h1234;
        tick();
        req1 = 1'b0; addr1 = 6'd10; wdata1 = 16'hFFFF;
        repeat (3) tick();
        access(1, 1'b0, 6'd9, '0);
        access(1, 1'b0, 6'd10, '0);
        access(0, 1'b0, 6'd3, '0);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                chk("cap_addr9",  k, 32'(rr_log[1].data), 32'h00001234);
                chk("cap_addr10", k, 32'(rr_log[2].data), 32'h0000A00A);
                chk("abort_addr3", k, 32'(rr_log[3].data), 32'h0000A003);
            end else begin
                chk("cap_addr9",  k, 32'(fp_log[1].data), 32'h00001234);
                chk("cap_addr10", k, 32'(fp_log[2].data), 32'h0000A00A);
                chk("abort_addr3", k, 32'(fp_log[3].data), 32'h0000A003);
            end
        end

        // Random traffic, occasional reset, checked by the model every cycle.
        repeat (400) begin
            rst    = ($urandom_range(0, 49) == 0);
            req0   = $urandom_range(0, 1) == 1;
            we0    = $urandom_range(0, 1) == 1;
            addr0  = AW'($urandom_range(0, 63));
            wdata0 = DW'($urandom);
            req1   = $urandom_range(0, 1) == 1;
            we1    = $urandom_range(0, 1) == 1;
            addr1  = AW'($urandom_range(0, 63));
            wdata1 = DW'($urandom);
            tick();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (4) tick();

        // Quiet bus for 10 cycles.
        rr_log.delete(); fp_log.delete();
        repeat (10) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                chk("idle_busy",   k, 32'(busy_w[k]),   0);
                chk("idle_mem_we", k, 32'(mem_we_w[k]), 0);
                chk("idle_ack0",   k, 32'(ack0_w[k]),   0);
                chk("idle_ack1",   k, 32'(ack1_w[k]),   0);
            end
        end
        chk("idle_no_ack", 0, rr_log.size() + fp_log.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
